// File: rtl/rom_loader_if.sv
// ioctl download stream and SDRAM write slot signals
// bundled for the rom_loader bridge.
interface rom_loader_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 8
);
    localparam int BYTES = DATA_W / 8;

    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              mem_sync;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [BYTES-1:0]  mem_be;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr,
        output ioctl_addr, ioctl_dout, mem_sync,
        input  mem_we, mem_addr, mem_data, mem_be
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr,
        input  ioctl_addr, ioctl_dout, mem_sync,
        output mem_we, mem_addr, mem_data, mem_be
    );
endinterface

// File: rtl/rom_loader.sv
// Download-to-memory bridge: region mapping, optional
// 16-bit word packing, write FIFO and slot-aligned drain.
module rom_loader #(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int REGIONS    = 4,
    parameter logic [REGIONS*ADDR_W-1:0] BASE_TABLE = '0
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    rom_loader_if.slave bus,
    output logic        busy,
    output logic        overflow,
    output logic        done
);
    localparam int BYTES = DATA_W / 8;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int EW    = ADDR_W + DATA_W + BYTES;
    localparam logic [8:0] NREG = 9'(REGIONS);

    logic              dl_q;
    logic              started;
    logic              busy_q;
    logic              rise;
    logic              accept;
    logic              pk_valid;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] target;
    logic              push;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;
    logic [BYTES-1:0]  push_be;

    assign rise   = bus.ioctl_download & ~dl_q;
    assign accept = bus.ioctl_wr & bus.ioctl_download &
                    ({1'b0, bus.ioctl_index} < NREG);

    always_comb begin
        base = '0;
        for (int i = 0; i < REGIONS; i++)
            if (bus.ioctl_index == 8'(i))
                base = BASE_TABLE[i*ADDR_W +: ADDR_W];
    end

    assign target = base + bus.ioctl_addr;

    generate
        if (DATA_W == 16) begin : g_pack
            logic              fall;
            logic              lane;
            logic              eff_v;
            logic              hit;
            logic              full_word;
            logic              pk_v;
            logic [ADDR_W-2:0] pk_wa;
            logic [15:0]       pk_d;
            logic [15:0]       ld;
            logic [1:0]        pk_be;
            logic [1:0]        lbe;

            assign fall  = ~bus.ioctl_download & dl_q;
            assign lane  = target[0];
            // a download rise discards whatever the packer held
            assign eff_v = pk_v & ~rise;
            assign lbe   = lane ? 2'b10 : 2'b01;
            assign ld    = lane ? {bus.ioctl_dout, 8'h00}
                                : {8'h00, bus.ioctl_dout};
            assign hit   = eff_v &
                           (pk_wa == target[ADDR_W-1:1]) &
                           ~|(pk_be & lbe);
            assign full_word = (pk_be | lbe) == 2'b11;

            always_comb begin
                push      = 1'b0;
                push_addr = {pk_wa, 1'b0};
                push_data = pk_d;
                push_be   = pk_be;
                if (fall & pk_v) begin
                    push = 1'b1;
                end else if (accept & eff_v & ~hit) begin
                    push = 1'b1;
                end else if (accept & hit & full_word) begin
                    push      = 1'b1;
                    push_data = pk_d | ld;
                    push_be   = 2'b11;
                end
            end

            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    pk_v  <= 1'b0;
                    pk_wa <= '0;
                    pk_d  <= '0;
                    pk_be <= '0;
                end else if (accept) begin
                    if (hit) begin
                        if (full_word) begin
                            pk_v <= 1'b0;
                        end else begin
                            pk_d  <= pk_d | ld;
                            pk_be <= pk_be | lbe;
                        end
                    end else begin
                        pk_v  <= 1'b1;
                        pk_wa <= target[ADDR_W-1:1];
                        pk_d  <= ld;
                        pk_be <= lbe;
                    end
                end else if (fall | rise) begin
                    pk_v <= 1'b0;
                end
            end

            assign pk_valid = pk_v;
        end else begin : g_byte
            assign push      = accept;
            assign push_addr = target;
            assign push_data = bus.ioctl_dout;
            assign push_be   = '1;
            assign pk_valid  = 1'b0;
        end
    endgenerate

    logic [EW-1:0] fifo [FIFO_DEPTH];
    logic [PW:0]   wp;
    logic [PW:0]   rp;
    logic          empty;
    logic          full;
    logic          pop;
    logic          wr_en;

    assign empty = wp == rp;
    assign full  = (wp[PW] != rp[PW]) &&
                   (wp[PW-1:0] == rp[PW-1:0]);
    assign pop   = bus.mem_sync & ~empty;
    // a pop in the same cycle frees the slot for a push
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clk_sys) begin
        if (wr_en)
            fifo[wp[PW-1:0]] <= {push_addr, push_data, push_be};
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wp           <= '0;
            rp           <= '0;
            dl_q         <= 1'b0;
            started      <= 1'b0;
            busy_q       <= 1'b0;
            overflow     <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_data <= '0;
            bus.mem_be   <= '0;
        end else begin
            dl_q   <= bus.ioctl_download;
            busy_q <= busy;
            if (rise)
                started <= 1'b1;
            if (wr_en)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            if (push & full & ~pop)
                overflow <= 1'b1;
            else if (rise)
                overflow <= 1'b0;
            if (bus.mem_sync) begin
                bus.mem_we <= ~empty;
                if (~empty)
                    {bus.mem_addr, bus.mem_data, bus.mem_be}
                        <= fifo[rp[PW-1:0]];
            end
        end
    end

    assign busy = dl_q | pk_valid | ~empty | bus.mem_we;
    assign done = started & busy_q & ~busy;
endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: byte and word-packing instances
// checked against queue-based reference models.
module tb_rom_loader;
    localparam int AW = 25;
    localparam logic [4*AW-1:0] BT8 = {
        25'h1FFFF00, 25'h0123456, 25'h0040000, 25'h0080000};
    localparam logic [4*AW-1:0] BT16 = {
        25'h0200000, 25'h1FFFFFF, 25'h0000101, 25'h01A0000};

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   d;
        logic [1:0]    be;
    } ent_t;

    logic [AW-1:0] base8 [4] = '{25'h0080000, 25'h0040000,
                                 25'h0123456, 25'h1FFFF00};
    logic [AW-1:0] base16[4] = '{25'h01A0000, 25'h0000101,
                                 25'h1FFFFFF, 25'h0200000};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rom_loader_if #(.ADDR_W(AW), .DATA_W(8))  b8 ();
    rom_loader_if #(.ADDR_W(AW), .DATA_W(16)) b16 ();

    logic busy8, ovf8, done8;
    logic busy16, ovf16, done16;

    rom_loader #(
        .ADDR_W(AW), .DATA_W(8), .FIFO_DEPTH(4),
        .REGIONS(4), .BASE_TABLE(BT8)
    ) dut8 (
        .clk_sys(clk), .reset_n(rst_n), .bus(b8.slave),
        .busy(busy8), .overflow(ovf8), .done(done8)
    );

    rom_loader #(
        .ADDR_W(AW), .DATA_W(16), .FIFO_DEPTH(4),
        .REGIONS(4), .BASE_TABLE(BT16)
    ) dut16 (
        .clk_sys(clk), .reset_n(rst_n), .bus(b16.slave),
        .busy(busy16), .overflow(ovf16), .done(done16)
    );

    int total = 0;
    int passed = 0;
    int dcnt8 = 0;
    int dcnt16 = 0;

    always @(posedge clk) begin
        if (done8)  dcnt8  <= dcnt8 + 1;
        if (done16) dcnt16 <= dcnt16 + 1;
    end

    ent_t          q8[$];
    ent_t          q16[$];
    bit            pv;
    logic [AW-2:0] pwa;
    logic [15:0]   pd;
    logic [1:0]    pbe;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic flush16;
        ent_t e;
        e.a = {pwa, 1'b0};
        e.d = pd;
        e.be = pbe;
        if (q16.size() < 4) q16.push_back(e);
        pv = 1'b0;
    endtask

    task automatic wr8(input logic [7:0] idx,
                       input logic [AW-1:0] a,
                       input logic [7:0] d);
        ent_t e;
        b8.ioctl_index = idx;
        b8.ioctl_addr = a;
        b8.ioctl_dout = d;
        b8.ioctl_wr = 1'b1;
        tick;
        b8.ioctl_wr = 1'b0;
        tick;
        if (b8.ioctl_download && idx < 8'd4) begin
            e.a = base8[idx] + a;
            e.d = {8'h00, d};
            e.be = 2'b01;
            if (q8.size() < 4) q8.push_back(e);
        end
    endtask

    task automatic wr16(input logic [7:0] idx,
                        input logic [AW-1:0] a,
                        input logic [7:0] d);
        logic [AW-1:0] t;
        b16.ioctl_index = idx;
        b16.ioctl_addr = a;
        b16.ioctl_dout = d;
        b16.ioctl_wr = 1'b1;
        tick;
        b16.ioctl_wr = 1'b0;
        tick;
        if (b16.ioctl_download && idx < 8'd4) begin
            t = base16[idx] + a;
            if (pv && (t[AW-1:1] != pwa || pbe[t[0]]))
                flush16;
            if (!pv) begin
                pv = 1'b1;
                pwa = t[AW-1:1];
                pd = '0;
                pbe = '0;
            end
            pd[t[0]*8 +: 8] = d;
            pbe[t[0]] = 1'b1;
            if (pbe == 2'b11) flush16;
        end
    endtask

    task automatic dl8(input logic v);
        b8.ioctl_download = v;
        tick;
        tick;
    endtask

    task automatic dl16(input logic v);
        b16.ioctl_download = v;
        if (!v && pv) flush16;
        if (v) pv = 1'b0;
        tick;
        tick;
    endtask

    task automatic sync8(input int gap);
        bit ew;
        ent_t e;
        ew = q8.size() > 0;
        if (ew) e = q8.pop_front();
        b8.mem_sync = 1'b1;
        tick;
        b8.mem_sync = 1'b0;
        total++;
        if (b8.mem_we !== ew)
            $display("FAIL we8 got %0b exp %0b", b8.mem_we, ew);
        else passed++;
        if (ew) begin
            total++;
            if ({b8.mem_addr, b8.mem_data, b8.mem_be} !==
                {e.a, e.d[7:0], e.be[0]})
                $display("FAIL wr8 got %h/%h/%b exp %h/%h/%b",
                         b8.mem_addr, b8.mem_data, b8.mem_be,
                         e.a, e.d[7:0], e.be[0]);
            else passed++;
        end
        repeat (gap) tick;
    endtask

    task automatic sync16(input int gap);
        bit ew;
        ent_t e;
        ew = q16.size() > 0;
        if (ew) e = q16.pop_front();
        b16.mem_sync = 1'b1;
        tick;
        b16.mem_sync = 1'b0;
        total++;
        if (b16.mem_we !== ew)
            $display("FAIL we16 got %0b exp %0b", b16.mem_we, ew);
        else passed++;
        if (ew) begin
            total++;
            if ({b16.mem_addr, b16.mem_data, b16.mem_be} !==
                {e.a, e.d, e.be})
                $display("FAIL wr16 got %h/%h/%b exp %h/%h/%b",
                         b16.mem_addr, b16.mem_data, b16.mem_be,
                         e.a, e.d, e.be);
            else passed++;
        end
        repeat (gap) tick;
    endtask

    task automatic drain8(input int gap);
        while (q8.size() > 0) sync8(gap);
        sync8(gap);
    endtask

    task automatic drain16(input int gap);
        while (q16.size() > 0) sync16(gap);
        sync16(gap);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) tick;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({b8.mem_we, b8.mem_addr, b8.mem_data, b8.mem_be,
                 busy8, ovf8, done8} !== '0)
                $display("FAIL reset8 got %b%h%h%b%b%b%b exp 0",
                         b8.mem_we, b8.mem_addr, b8.mem_data,
                         b8.mem_be, busy8, ovf8, done8);
            else passed++;
            total++;
            if ({b16.mem_we, b16.mem_addr, b16.mem_data, b16.mem_be,
                 busy16, ovf16, done16} !== '0)
                $display("FAIL reset16 got %b%h%h%b%b%b%b exp 0",
                         b16.mem_we, b16.mem_addr, b16.mem_data,
                         b16.mem_be, busy16, ovf16, done16);
            else passed++;
            rst_n = 1'b1;
            repeat (2) tick;
        end
    endtask

    task automatic test_map8;
        int d0;
        d0 = dcnt8;
        dl8(1'b1);
        wr8(8'd0, 25'd0, 8'h11);
        wr8(8'd0, 25'd1, 8'h22);
        dl8(1'b0);
        drain8(7);
        tick;
        total++;
        if (dcnt8 - d0 !== 1)
            $display("FAIL done_map8 got %0d exp 1", dcnt8 - d0);
        else passed++;
    endtask

    task automatic test_random8;
        int d0, n;
        logic [7:0] idx;
        for (int r = 0; r < 4; r++) begin
            d0 = dcnt8;
            dl8(1'b1);
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 4) == 0)
                    idx = 8'($urandom_range(4, 255));
                else
                    idx = 8'($urandom_range(0, 3));
                wr8(idx, AW'($urandom), 8'($urandom));
            end
            dl8(1'b0);
            while (q8.size() > 0) sync8($urandom_range(1, 6));
            sync8(2);
            total++;
            if (dcnt8 - d0 !== 1)
                $display("FAIL done_rnd8 got %0d exp 1", dcnt8 - d0);
            else passed++;
        end
    endtask

    task automatic test_ignored;
        int d0;
        d0 = dcnt8;
        b8.ioctl_download = 1'b1;
        tick;
        total++;
        if (busy8 !== 1'b1)
            $display("FAIL busy_ign_hi got %b exp 1", busy8);
        else passed++;
        wr8(8'hFF, 25'd3, 8'h5A);
        wr8(8'd4, 25'd7, 8'hA5);
        sync8(1);
        total++;
        if (busy8 !== 1'b1)
            $display("FAIL busy_ign_dl got %b exp 1", busy8);
        else passed++;
        b8.ioctl_download = 1'b0;
        tick;
        total++;
        if (busy8 !== 1'b0)
            $display("FAIL busy_ign_lo got %b exp 0", busy8);
        else passed++;
        tick;
        tick;
        sync8(1);
        total++;
        if (dcnt8 - d0 !== 1)
            $display("FAIL done_ign got %0d exp 1", dcnt8 - d0);
        else passed++;
    endtask

    task automatic test_overflow;
        dl8(1'b1);
        for (int i = 0; i < 6; i++) begin
            wr8(8'd1, AW'(i), 8'($urandom));
            if (i == 3) begin
                total++;
                if (ovf8 !== 1'b0)
                    $display("FAIL ovf_b4 got %b exp 0", ovf8);
                else passed++;
            end
            if (i == 4) begin
                total++;
                if (ovf8 !== 1'b1)
                    $display("FAIL ovf_b5 got %b exp 1", ovf8);
                else passed++;
            end
        end
        dl8(1'b0);
        drain8(3);
        total++;
        if (ovf8 !== 1'b1)
            $display("FAIL ovf_sticky got %b exp 1", ovf8);
        else passed++;
        b8.ioctl_download = 1'b1;
        tick;
        total++;
        if (ovf8 !== 1'b0)
            $display("FAIL ovf_clear got %b exp 0", ovf8);
        else passed++;
        dl8(1'b0);
        tick;
    endtask

    task automatic test_full_simul;
        ent_t e, n;
        logic [7:0] d;
        dl8(1'b1);
        for (int i = 0; i < 4; i++)
            wr8(8'd2, AW'(i), 8'($urandom));
        d = 8'($urandom);
        e = q8.pop_front();
        n.a = base8[2] + 25'd4;
        n.d = {8'h00, d};
        n.be = 2'b01;
        q8.push_back(n);
        b8.ioctl_index = 8'd2;
        b8.ioctl_addr = 25'd4;
        b8.ioctl_dout = d;
        b8.ioctl_wr = 1'b1;
        b8.mem_sync = 1'b1;
        tick;
        b8.ioctl_wr = 1'b0;
        b8.mem_sync = 1'b0;
        total++;
        if ({b8.mem_we, b8.mem_addr, b8.mem_data} !==
            {1'b1, e.a, e.d[7:0]})
            $display("FAIL simul_pop got %b/%h/%h exp 1/%h/%h",
                     b8.mem_we, b8.mem_addr, b8.mem_data,
                     e.a, e.d[7:0]);
        else passed++;
        tick;
        total++;
        if (ovf8 !== 1'b0)
            $display("FAIL simul_ovf got %b exp 0", ovf8);
        else passed++;
        dl8(1'b0);
        drain8(2);
    endtask

    task automatic test_pack16;
        int d0;
        d0 = dcnt16;
        dl16(1'b1);
        wr16(8'd0, 25'd4, 8'hAA);
        wr16(8'd0, 25'd5, 8'hBB);
        wr16(8'd0, 25'd6, 8'hCC);
        dl16(1'b0);
        drain16(7);
        tick;
        total++;
        if (dcnt16 - d0 !== 1)
            $display("FAIL done_pack got %0d exp 1", dcnt16 - d0);
        else passed++;
    endtask

    task automatic test_random16;
        int n;
        logic [7:0] idx;
        for (int r = 0; r < 5; r++) begin
            dl16(1'b1);
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 5) == 0) idx = 8'hFF;
                else idx = 8'($urandom_range(0, 3));
                wr16(idx, AW'($urandom_range(0, 5)), 8'($urandom));
            end
            dl16(1'b0);
            while (q16.size() > 0) sync16($urandom_range(1, 6));
            sync16(2);
        end
        total++;
        if (ovf16 !== 1'b0)
            $display("FAIL ovf16 got %b exp 0", ovf16);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int d0;
        dl8(1'b1);
        for (int i = 0; i < 4; i++)
            wr8(8'd3, AW'(300 + i), 8'($urandom));
        sync8(0);
        d0 = dcnt8;
        rst_n = 1'b0;
        #1;
        total++;
        if ({b8.mem_we, b8.mem_addr, b8.mem_data, b8.mem_be,
             busy8, ovf8, done8} !== '0)
            $display("FAIL reset_mid got %b%h%h%b%b%b%b exp 0",
                     b8.mem_we, b8.mem_addr, b8.mem_data,
                     b8.mem_be, busy8, ovf8, done8);
        else passed++;
        b8.ioctl_download = 1'b0;
        q8.delete();
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        total++;
        if (busy8 !== 1'b0)
            $display("FAIL busy_post_rst got %b exp 0", busy8);
        else passed++;
        sync8(2);
        sync8(2);
        total++;
        if (dcnt8 !== d0)
            $display("FAIL done_post_rst got %0d exp %0d", dcnt8, d0);
        else passed++;
    endtask

    initial begin
        b8.ioctl_download = 1'b0;
        b8.ioctl_index = '0;
        b8.ioctl_wr = 1'b0;
        b8.ioctl_addr = '0;
        b8.ioctl_dout = '0;
        b8.mem_sync = 1'b0;
        b16.ioctl_download = 1'b0;
        b16.ioctl_index = '0;
        b16.ioctl_wr = 1'b0;
        b16.ioctl_addr = '0;
        b16.ioctl_dout = '0;
        b16.mem_sync = 1'b0;
        pv = 1'b0;
        pwa = '0;
        pd = '0;
        pbe = '0;
        test_reset;
        test_map8;
        test_random8;
        test_ignored;
        test_overflow;
        test_full_simul;
        test_pack16;
        test_random16;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
